ntt_addr_gen: RTL and testbench
===============================

# ntt_addr_gen

Sequencer for the NTT datapath, sitting directly upstream of `butterfly`. It walks all layers of a 256-point forward (Cooley-Tukey) or inverse (Gentleman-Sande) NTT for Kyber or Dilithium. It issues one coefficient-pair read, with the matching zeta ROM address, per cycle, and drives `sel_red`/`sel_butterfly` for the butterfly. It then replays the same addresses as in-place write-backs once read data has passed through the combinational butterfly.

## Interface

Parameters:
- `RD_LAT`, default 1: read latency of the coefficient RAM and zeta ROM, in cycles. Legal range 1..4.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  start request; sampled only in IDLE.
- `sel_red_i`  in  1  1 = Kyber (q=3329, 7 layers), 0 = Dilithium (q=8380417, 8 layers); latched on start.
- `inverse_i`  in  1  0 = forward NTT, 1 = inverse NTT; latched on start.
- `busy_o`  out  1  high in RUN and DRAIN.
- `done_o`  out  1  one-cycle completion pulse.
- `rd_en_o`  out  1  coefficient read strobe (both ports).
- `rd_addr_a_o`, `rd_addr_b_o`  out  8  pair addresses (a, b = a + len).
- `zeta_addr_o`  out  8  twiddle ROM index; valid when `rd_en_o` is high.
- `sel_red_o`  out  1  latched `sel_red_i`; drives `butterfly.sel_red_i`.
- `sel_butterfly_o`  out  1  latched `inverse_i`; drives `butterfly.sel_butterfly_i`.
- `wr_en_o`  out  1  write strobe = `rd_en_o` delayed `RD_LAT` cycles.
- `wr_addr_a_o`, `wr_addr_b_o`  out  8  read addresses delayed `RD_LAT` cycles.

## Operation

- States:
  - IDLE: on `start_i`, latch the mode inputs, load the first layer, go to RUN.
  - RUN: 128 cycles per layer.
  - DRAIN: `RD_LAT` cycles with `rd_en_o` = 0, so the last write-backs of a layer land before the next layer reads.
  - After DRAIN: go to RUN for the next layer, or to DONE after the last layer.
  - DONE: 1 cycle, then IDLE.
- Layer count: L = 7 (Kyber) or 8 (Dilithium).
  - Layer index l runs 0..L-1 ascending for forward, L-1..0 descending for inverse.
  - len = 128 >> l.
- Butterfly counter c runs 0..127 within a layer.
  - Let s = 7 - l, g = c >> s, off = c & (len - 1).
  - a = (g << (s+1)) | off; b = a + len.
- Zeta index:
  - Forward: 2^l + g. Kyber gives 1..127; Dilithium gives 1..255.
  - Inverse: 2^(l+1) - 1 - g. Descending, 127..1 or 255..1.
  - Zeta sign handling (Dilithium inverse negation) lives in the ROM/butterfly, not here.
- `start_i` while busy or in DONE is ignored.
- `sel_red_i` and `inverse_i` changes after start have no effect until the next start.
- The write pipeline is a shift register of depth `RD_LAT` on {rd_en, addr_a, addr_b}. It keeps draining in DONE and IDLE.
- Reset (any time, including mid-layer) returns to IDLE immediately.
  - All outputs, counters and the write pipeline go to 0; the interrupted transform is abandoned.
  - Reset values: every output = 0.

## Timing

- Start accepted at edge E0. `rd_en_o` is high for cycles E0+1 .. E0+128 (layer 0), then low for `RD_LAT` cycles, and so on.
- `done_o` is high for the single cycle following edge E0 + L·(128 + `RD_LAT`):
  - Kyber, `RD_LAT`=1: 903.
  - Dilithium, `RD_LAT`=1: 1032.
- The last `wr_en_o` pulse falls no later than the edge that raises `done_o`.
- `busy_o` is low in the `done_o` cycle. A new `start_i` is accepted from the following IDLE cycle.
- Addresses and zeta index are registered outputs; there is no combinational path from inputs to outputs.

## Configuration

- `NTT_DILITHIUM_EN` defined:
  - Both schemes are supported as above.
- `NTT_DILITHIUM_EN` undefined:
  - `sel_red_i` is ignored and `sel_red_o` is tied to 1.
  - L is fixed at 7.
  - `zeta_addr_o[7]` is constant 0.
  - The layer-7 (len=1) address path is removed.

## Test plan

- Kyber forward, `RD_LAT`=1, start at E0:
  - First read is a=0, b=128, zeta=1.
  - 129 cycles later (layer 1, c=0): a=0, b=64, zeta=2.
  - `done_o` follows edge E0+903; exactly 896 `wr_en_o` pulses.
- Kyber forward, layer l=6, c=5 -> a=9, b=11, zeta=66.
  - The same pair appears on `wr_addr` one cycle later.
- Dilithium inverse:
  - First reads: (0,1,zeta=255), then (2,3,254).
  - Final layer, c=0: (0,128,zeta=1).
  - `done_o` follows edge E0+1032; `sel_butterfly_o`=1 and `sel_red_o`=0 throughout.
- `RD_LAT`=3:
  - Each layer boundary shows exactly 3 `rd_en_o`-low cycles.
  - The last write of a layer precedes the first read of the next.
- `start_i` pulsed at cycle 50 of a run -> no effect.
- `rst_n_i` low at cycle 300 -> all outputs 0 asynchronously; a fresh start restarts at a=0, b=128, zeta=1.
- Build without `NTT_DILITHIUM_EN`, start with `sel_red_i`=0 -> 7 layers, `done_o` after 903 cycles, `sel_red_o`=1.

Source files
------------

// File: rtl/ntt_addr_gen.sv
// NTT layer sequencer: per-cycle coefficient-pair read addresses, zeta index and delayed write-back addresses.
// Optional feature macro NTT_DILITHIUM_EN enables the 8-layer Dilithium mode; without it only Kyber (7 layers) exists.
module ntt_addr_gen #(
    parameter int RD_LAT = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic       sel_red_i,
    input  logic       inverse_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       rd_en_o,
    output logic [7:0] rd_addr_a_o,
    output logic [7:0] rd_addr_b_o,
    output logic [7:0] zeta_addr_o,
    output logic       sel_red_o,
    output logic       sel_butterfly_o,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_a_o,
    output logic [7:0] wr_addr_b_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT - 1);

    state_t     state, nxt_state;
    logic [2:0] layer, nxt_layer;
    logic [6:0] cnt, nxt_cnt;
    logic [2:0] dcnt, nxt_dcnt;
    logic       inv, nxt_inv;
    logic [2:0] top_layer, start_top;
    logic       last_layer;

    logic [2:0] s;
    logic [7:0] len, g, off, a_nxt, z_nxt;

`ifdef NTT_DILITHIUM_EN
    logic kyb;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            kyb <= 1'b0;
        end else if (state == IDLE && start_i) begin
            kyb <= sel_red_i;
        end
    end

    assign sel_red_o = kyb;
    assign top_layer = kyb ? 3'd6 : 3'd7;
    assign start_top = sel_red_i ? 3'd6 : 3'd7;
`else
    logic unused_sel_red;

    assign unused_sel_red = sel_red_i;
    assign sel_red_o      = 1'b1;
    assign top_layer      = 3'd6;
    assign start_top      = 3'd6;
`endif

    // Forward walks layers upward, inverse walks them downward.
    assign last_layer = inv ? (layer == 3'd0) : (layer == top_layer);

    always_comb begin
        nxt_state = state;
        nxt_layer = layer;
        nxt_cnt   = cnt;
        nxt_dcnt  = dcnt;
        nxt_inv   = inv;
        case (state)
            IDLE: begin
                if (start_i) begin
                    nxt_state = RUN;
                    nxt_inv   = inverse_i;
                    nxt_layer = inverse_i ? start_top : 3'd0;
                    nxt_cnt   = 7'd0;
                end
            end
            RUN: begin
                nxt_cnt = cnt + 7'd1;
                if (cnt == 7'd127) begin
                    nxt_state = DRAIN;
                    nxt_dcnt  = 3'd0;
                end
            end
            DRAIN: begin
                if (dcnt == DRAIN_LAST) begin
                    if (last_layer) begin
                        nxt_state = DONE;
                    end else begin
                        nxt_state = RUN;
                        nxt_layer = inv ? layer - 3'd1 : layer + 3'd1;
                        nxt_cnt   = 7'd0;
                    end
                end else begin
                    nxt_dcnt = dcnt + 3'd1;
                end
            end
            DONE: nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Pair addresses for the upcoming cycle, computed from the next counter values so outputs are registered.
    always_comb begin
        s     = 3'd7 - nxt_layer;
        len   = 8'd128 >> nxt_layer;
        g     = {1'b0, nxt_cnt} >> s;
        off   = {1'b0, nxt_cnt} & (len - 8'd1);
        a_nxt = (g << ({1'b0, s} + 4'd1)) | off;
    end

`ifdef NTT_DILITHIUM_EN
    assign z_nxt = nxt_inv ? ((8'd2 << nxt_layer) - 8'd1 - g) : ((8'd1 << nxt_layer) + g);
`else
    logic [6:0] z7;

    assign z7    = nxt_inv ? ((7'd2 << nxt_layer) - 7'd1 - g[6:0]) : ((7'd1 << nxt_layer) + g[6:0]);
    assign z_nxt = {1'b0, z7};
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= IDLE;
            layer           <= 3'd0;
            cnt             <= 7'd0;
            dcnt            <= 3'd0;
            inv             <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            rd_en_o         <= 1'b0;
            rd_addr_a_o     <= 8'd0;
            rd_addr_b_o     <= 8'd0;
            zeta_addr_o     <= 8'd0;
            sel_butterfly_o <= 1'b0;
        end else begin
            state           <= nxt_state;
            layer           <= nxt_layer;
            cnt             <= nxt_cnt;
            dcnt            <= nxt_dcnt;
            inv             <= nxt_inv;
            busy_o          <= (nxt_state == RUN) || (nxt_state == DRAIN);
            done_o          <= (nxt_state == DONE);
            rd_en_o         <= (nxt_state == RUN);
            rd_addr_a_o     <= (nxt_state == RUN) ? a_nxt : 8'd0;
            rd_addr_b_o     <= (nxt_state == RUN) ? a_nxt + len : 8'd0;
            zeta_addr_o     <= (nxt_state == RUN) ? z_nxt : 8'd0;
            sel_butterfly_o <= nxt_inv;
        end
    end

    // Write-back replay: keeps shifting in every state so the tail drains through DONE/IDLE.
    logic [RD_LAT-1:0] pipe_en;
    logic [7:0]        pipe_a [RD_LAT];
    logic [7:0]        pipe_b [RD_LAT];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pipe_en <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_a[i] <= 8'd0;
                pipe_b[i] <= 8'd0;
            end
        end else begin
            pipe_en[0] <= rd_en_o;
            pipe_a[0]  <= rd_addr_a_o;
            pipe_b[0]  <= rd_addr_b_o;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_en[i] <= pipe_en[i-1];
                pipe_a[i]  <= pipe_a[i-1];
                pipe_b[i]  <= pipe_b[i-1];
            end
        end
    end

    assign wr_en_o     = pipe_en[RD_LAT-1];
    assign wr_addr_a_o = pipe_a[RD_LAT-1];
    assign wr_addr_b_o = pipe_b[RD_LAT-1];

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Scoreboard bench for ntt_addr_gen: two instances (read latency 1 and 3) checked against a loop-based NTT address model.
module tb_ntt_addr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, sel_red, inverse;

    logic       b1, dn1, re1, sr1, sb1, we1;
    logic [7:0] ra1, rb1, z1, wa1, wb1;
    logic       b3, dn3, re3, sr3, sb3, we3;
    logic [7:0] ra3, rb3, z3, wa3, wb3;

    ntt_addr_gen #(.RD_LAT(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .sel_red_i(sel_red), .inverse_i(inverse),
        .busy_o(b1), .done_o(dn1), .rd_en_o(re1), .rd_addr_a_o(ra1), .rd_addr_b_o(rb1),
        .zeta_addr_o(z1), .sel_red_o(sr1), .sel_butterfly_o(sb1), .wr_en_o(we1),
        .wr_addr_a_o(wa1), .wr_addr_b_o(wb1));

    ntt_addr_gen #(.RD_LAT(3)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .sel_red_i(sel_red), .inverse_i(inverse),
        .busy_o(b3), .done_o(dn3), .rd_en_o(re3), .rd_addr_a_o(ra3), .rd_addr_b_o(rb3),
        .zeta_addr_o(z3), .sel_red_o(sr3), .sel_butterfly_o(sb3), .wr_en_o(we3),
        .wr_addr_a_o(wa3), .wr_addr_b_o(wb3));

`ifdef NTT_DILITHIUM_EN
    localparam logic RST_SR = 1'b0;
`else
    localparam logic RST_SR = 1'b1;
`endif

    typedef struct {
        int         off;
        logic [7:0] a, b, z;
        logic       sr, sb;
    } exp_t;

    exp_t rq1[$], wq1[$], rq3[$], wq3[$];
    int   dq1[$], dq3[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, t0 = 0, done_seen = 0;
    logic probe_on = 1'b0;
    logic [23:0] p0, p1, p2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (dut%0d): got %0d, expected %0d", nm, (d == 0) ? 1 : 3, act, exp);
        end
    endtask

    // Reference: classic in-place NTT loops; zeta index is a running counter stepped once per group.
    task automatic push_run(input bit kyb, input bit inv);
        int nl, rd, k, l, len, c;
        exp_t e;
        nl = kyb ? 7 : 8;
        for (int d = 0; d < 2; d++) begin
            rd = (d == 0) ? 1 : 3;
            k  = inv ? (1 << nl) - 1 : 1;
            for (int p = 0; p < nl; p++) begin
                l   = inv ? nl - 1 - p : p;
                len = 128 >> l;
                c   = 0;
                for (int st = 0; st < 256; st += 2 * len) begin
                    for (int j = st; j < st + len; j++) begin
                        e.off = p * (128 + rd) + c;
                        e.a   = 8'(j);
                        e.b   = 8'(j + len);
                        e.z   = 8'(k);
                        e.sr  = kyb;
                        e.sb  = inv;
                        if (d == 0) rq1.push_back(e); else rq3.push_back(e);
                        e.off = e.off + rd;
                        if (d == 0) wq1.push_back(e); else wq3.push_back(e);
                        c++;
                    end
                    k = inv ? k - 1 : k + 1;
                end
            end
            if (d == 0) dq1.push_back(nl * (128 + rd)); else dq3.push_back(nl * (128 + rd));
        end
    endtask

    task automatic mon(input int d, input int off, input logic re, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] z, input logic sr, input logic sb, input logic we,
                       input logic [7:0] wa, input logic [7:0] wb, input logic dn, input logic bu);
        exp_t e;
        if (re) begin
            if ((d == 0 && rq1.size() == 0) || (d == 1 && rq3.size() == 0)) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_unexpected (dut%0d): read at offset %0d, expected none", (d == 0) ? 1 : 3, off);
            end else begin
                if (d == 0) e = rq1.pop_front(); else e = rq3.pop_front();
                check("rd_offset", d, off, e.off);
                check("rd_addr_a", d, {24'd0, a}, {24'd0, e.a});
                check("rd_addr_b", d, {24'd0, b}, {24'd0, e.b});
                check("zeta_addr", d, {24'd0, z}, {24'd0, e.z});
                check("sel_red", d, {31'd0, sr}, {31'd0, e.sr});
                check("sel_butterfly", d, {31'd0, sb}, {31'd0, e.sb});
            end
            if (d == 0 && probe_on) begin
                if (off == 0)   p0 = {a, b, z};
                if (off == 129) p1 = {a, b, z};
                if (off == 779) p2 = {a, b, z};
            end
        end
        if (we) begin
            if ((d == 0 && wq1.size() == 0) || (d == 1 && wq3.size() == 0)) begin
                n_cmp++; n_bad++;
                $display("FAIL wr_unexpected (dut%0d): write at offset %0d, expected none", (d == 0) ? 1 : 3, off);
            end else begin
                if (d == 0) e = wq1.pop_front(); else e = wq3.pop_front();
                check("wr_offset", d, off, e.off);
                check("wr_addr_a", d, {24'd0, wa}, {24'd0, e.a});
                check("wr_addr_b", d, {24'd0, wb}, {24'd0, e.b});
            end
        end
        if (dn) begin
            done_seen++;
            if ((d == 0 && dq1.size() == 0) || (d == 1 && dq3.size() == 0)) begin
                n_cmp++; n_bad++;
                $display("FAIL done_unexpected (dut%0d): done at offset %0d, expected none", (d == 0) ? 1 : 3, off);
            end else begin
                check("done_offset", d, off, (d == 0) ? dq1.pop_front() : dq3.pop_front());
            end
            check("busy_in_done", d, {31'd0, bu}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        int off;
        off = cyc - t0;
        if (rst_n) begin
            mon(0, off, re1, ra1, rb1, z1, sr1, sb1, we1, wa1, wb1, dn1, b1);
            mon(1, off, re3, ra3, rb3, z3, sr3, sb3, we3, wa3, wb3, dn3, b3);
        end
    end

    task automatic check_zero();
        check("rst_busy", 0, {31'd0, b1}, 32'd0);      check("rst_busy", 1, {31'd0, b3}, 32'd0);
        check("rst_done", 0, {31'd0, dn1}, 32'd0);     check("rst_done", 1, {31'd0, dn3}, 32'd0);
        check("rst_rd_en", 0, {31'd0, re1}, 32'd0);    check("rst_rd_en", 1, {31'd0, re3}, 32'd0);
        check("rst_rd_a", 0, {24'd0, ra1}, 32'd0);     check("rst_rd_a", 1, {24'd0, ra3}, 32'd0);
        check("rst_rd_b", 0, {24'd0, rb1}, 32'd0);     check("rst_rd_b", 1, {24'd0, rb3}, 32'd0);
        check("rst_zeta", 0, {24'd0, z1}, 32'd0);      check("rst_zeta", 1, {24'd0, z3}, 32'd0);
        check("rst_sel_red", 0, {31'd0, sr1}, {31'd0, RST_SR});
        check("rst_sel_red", 1, {31'd0, sr3}, {31'd0, RST_SR});
        check("rst_sel_bf", 0, {31'd0, sb1}, 32'd0);   check("rst_sel_bf", 1, {31'd0, sb3}, 32'd0);
        check("rst_wr_en", 0, {31'd0, we1}, 32'd0);    check("rst_wr_en", 1, {31'd0, we3}, 32'd0);
        check("rst_wr_a", 0, {24'd0, wa1}, 32'd0);     check("rst_wr_a", 1, {24'd0, wa3}, 32'd0);
        check("rst_wr_b", 0, {24'd0, wb1}, 32'd0);     check("rst_wr_b", 1, {24'd0, wb3}, 32'd0);
    endtask

    task automatic launch(input bit sr, input bit inv);
        logic kyb;
`ifdef NTT_DILITHIUM_EN
        kyb = sr;
`else
        kyb = 1'b1;
`endif
        @(negedge clk);
        push_run(kyb, inv);
        sel_red   = sr;
        inverse   = inv;
        start     = 1'b1;
        t0        = cyc + 1;
        done_seen = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input bit sr, input bit inv, input bit disturb);
        launch(sr, inv);
        if (disturb) begin
            // Start pulse and mode flips mid-layer must be ignored.
            repeat (49) @(negedge clk);
            start   = 1'b1;
            sel_red = ~sr;
            inverse = ~inv;
            @(negedge clk);
            start   = 1'b0;
        end
        for (int i = 0; i < 3000 && done_seen < 2; i++) @(negedge clk);
        check("done_timeout", 1, done_seen, 2);
        repeat (2) @(negedge clk);
        check("rd_left", 0, rq1.size(), 0);  check("rd_left", 1, rq3.size(), 0);
        check("wr_left", 0, wq1.size(), 0);  check("wr_left", 1, wq3.size(), 0);
        check("done_left", 0, dq1.size(), 0); check("done_left", 1, dq3.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sel_red = 1'b0; inverse = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_zero();
        @(negedge clk);
        rst_n = 1'b1;

        p0 = '1; p1 = '1; p2 = '1;
        probe_on = 1'b1;
        run(1'b1, 1'b0, 1'b0);
        probe_on = 1'b0;
        check("kyb_fwd_first", 0, {8'd0, p0}, {8'd0, 8'd0, 8'd128, 8'd1});
        check("kyb_fwd_layer1", 0, {8'd0, p1}, {8'd0, 8'd0, 8'd64, 8'd2});
        check("kyb_fwd_l6_c5", 0, {8'd0, p2}, {8'd0, 8'd9, 8'd11, 8'd66});

        run(1'b0, 1'b1, 1'b0);

        launch(1'b1, 1'b0);
        repeat (299) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero();
        rq1.delete(); wq1.delete(); rq3.delete(); wq3.delete(); dq1.delete(); dq3.delete();
        @(negedge clk);
        rst_n = 1'b1;

        p0 = '1;
        probe_on = 1'b1;
        run(1'b1, 1'b0, 1'b0);
        probe_on = 1'b0;
        check("restart_first", 0, {8'd0, p0}, {8'd0, 8'd0, 8'd128, 8'd1});

        for (int r = 0; r < 4; r++) begin
            run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
